// File: rtl/clk_monitor.sv
// Clock-integrity monitor: measures each half-period of a sampled clock,
// qualifies it after a run of in-tolerance half-periods, and flags short/long/stuck errors.
module clk_monitor #(
  parameter int unsigned HALF_PERIOD = 10,
  parameter int unsigned TOL         = 1,
  parameter int unsigned LOCK_CNT    = 4,
  parameter int unsigned STUCK_LIMIT = 32,
  parameter int unsigned CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mon_in,
  input  logic             enable,
  input  logic             clear_err,
  output logic             locked,
  output logic             err_short,
  output logic             err_long,
  output logic             err_stuck,
  output logic [CNT_W-1:0] half_len,
  output logic [15:0]      edge_count
);

  // Bounds are held one bit wider than the counter so TOL > HALF_PERIOD clamps to 0.
  localparam logic [CNT_W:0] LEN_LO   = (TOL > HALF_PERIOD) ? '0 : (CNT_W+1)'(HALF_PERIOD - TOL);
  localparam logic [CNT_W:0] LEN_HI   = (CNT_W+1)'(HALF_PERIOD + TOL);
  localparam logic [CNT_W:0] STUCK    = (CNT_W+1)'(STUCK_LIMIT);
  localparam int unsigned    GW       = $clog2(LOCK_CNT + 1);
  localparam logic [GW:0]    GOOD_REQ = (GW+1)'(LOCK_CNT);

  typedef enum logic [1:0] {IDLE, ACQUIRE, MEASURE, LOCKED} state_e;

  state_e           state_q;
  logic             q1_q, q2_q, q3_q;
  logic [CNT_W-1:0] run_cnt_q;
  logic [GW-1:0]    good_q;
  logic             locked_q, err_short_q, err_long_q, err_stuck_q;
  logic [CNT_W-1:0] half_len_q;
  logic [15:0]      edge_count_q;

  logic             edge_det;
  logic [CNT_W:0]   len_d;
  logic [CNT_W-1:0] run_cnt_d;
  logic [GW:0]      good_d;
  logic             measuring, len_good, stuck_hit;
  logic             set_short, set_long, set_stuck;

  always_comb begin
    edge_det  = q2_q ^ q3_q;
    len_d     = {1'b0, run_cnt_q} + 1'b1;
    run_cnt_d = (run_cnt_q == '1) ? run_cnt_q : run_cnt_q + 1'b1;
    good_d    = {1'b0, good_q} + 1'b1;
    measuring = enable && (state_q == MEASURE || state_q == LOCKED);
    len_good  = (len_d >= LEN_LO) && (len_d <= LEN_HI);
    // Fires on the cycle the counter would reach STUCK_LIMIT-1.
    stuck_hit = !edge_det && ((len_d + 1'b1) >= STUCK);
    set_short = measuring && edge_det && (len_d < LEN_LO);
    set_long  = measuring && edge_det && (len_d > LEN_HI);
    set_stuck = measuring && stuck_hit;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      q1_q         <= 1'b0;
      q2_q         <= 1'b0;
      q3_q         <= 1'b0;
      run_cnt_q    <= '0;
      good_q       <= '0;
      locked_q     <= 1'b0;
      err_short_q  <= 1'b0;
      err_long_q   <= 1'b0;
      err_stuck_q  <= 1'b0;
      half_len_q   <= '0;
      edge_count_q <= '0;
    end else begin
      q1_q <= mon_in;
      q2_q <= q1_q;
      q3_q <= q2_q;

      err_short_q <= set_short | (err_short_q & ~clear_err);
      err_long_q  <= set_long  | (err_long_q  & ~clear_err);
      err_stuck_q <= set_stuck | (err_stuck_q & ~clear_err);

      if (enable && state_q != IDLE && edge_det)
        edge_count_q <= edge_count_q + 16'd1;

      if (!enable) begin
        state_q   <= IDLE;
        locked_q  <= 1'b0;
        run_cnt_q <= '0;
        good_q    <= '0;
      end else begin
        unique case (state_q)
          IDLE: begin
            state_q   <= ACQUIRE;
            run_cnt_q <= '0;
            good_q    <= '0;
          end
          ACQUIRE: begin
            run_cnt_q <= '0;
            good_q    <= '0;
            if (edge_det) state_q <= MEASURE;
          end
          MEASURE, LOCKED: begin
            if (edge_det) begin
              run_cnt_q  <= '0;
              half_len_q <= len_d[CNT_W-1:0];
              if (len_good) begin
                if (good_d >= GOOD_REQ) begin
                  state_q  <= LOCKED;
                  locked_q <= 1'b1;
                  good_q   <= GOOD_REQ[GW-1:0];
                end else begin
                  good_q <= good_d[GW-1:0];
                end
              end else begin
                state_q  <= MEASURE;
                locked_q <= 1'b0;
                good_q   <= '0;
              end
            end else if (stuck_hit) begin
              state_q    <= ACQUIRE;
              locked_q   <= 1'b0;
              good_q     <= '0;
              run_cnt_q  <= '0;
              half_len_q <= STUCK[CNT_W-1:0];
            end else begin
              run_cnt_q <= run_cnt_d;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign locked     = locked_q;
  assign err_short  = err_short_q;
  assign err_long   = err_long_q;
  assign err_stuck  = err_stuck_q;
  assign half_len   = half_len_q;
  assign edge_count = edge_count_q;

endmodule

// File: tb/tb_clk_monitor.sv
// Directed bench for clk_monitor at default parameters; expected values are hand-derived
// from toggle spacing (edge consumed 3 clk after a toggle, half-period = toggle spacing).
module tb_clk_monitor;

  logic        clk = 1'b0;
  logic        rst, mon_in, enable, clear_err;
  logic        locked, err_short, err_long, err_stuck;
  logic [7:0]  half_len;
  logic [15:0] edge_count;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  clk_monitor #(.HALF_PERIOD(10), .TOL(1), .LOCK_CNT(4), .STUCK_LIMIT(32), .CNT_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .mon_in     (mon_in),
    .enable     (enable),
    .clear_err  (clear_err),
    .locked     (locked),
    .err_short  (err_short),
    .err_long   (err_long),
    .err_stuck  (err_stuck),
    .half_len   (half_len),
    .edge_count (edge_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Toggle the monitored clock, then let n system cycles elapse.
  task automatic tw(input int n);
    mon_in = ~mon_in;
    repeat (n) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1; mon_in = 1'b0; enable = 1'b1; clear_err = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    repeat (2) tick();
  endtask

  task automatic check_errs(input string tag, input logic s, input logic l, input logic k);
    check({tag, "_short"}, err_short, s);
    check({tag, "_long"},  err_long,  l);
    check({tag, "_stuck"}, err_stuck, k);
  endtask

  initial begin
    rst = 1'b1; mon_in = 1'b0; enable = 1'b1; clear_err = 1'b0;
    tick();
    check("rst_locked", locked, 0);
    check_errs("rst", 0, 0, 0);
    check("rst_half_len", half_len, 0);
    check("rst_edge_count", edge_count, 0);

    // 1: nominal 10-cycle half-period, lock on the 5th edge
    do_reset();
    for (int e = 1; e <= 6; e++) begin
      tw(10);
      check($sformatf("s1_ec%0d", e), edge_count, e);
      check($sformatf("s1_hl%0d", e), half_len, (e == 1) ? 0 : 10);
      check($sformatf("s1_lk%0d", e), locked, (e >= 5) ? 1 : 0);
    end
    check_errs("s1", 0, 0, 0);

    // 2a: short half-period
    do_reset();
    for (int e = 1; e <= 6; e++) begin
      tw(7);
      check($sformatf("s2a_lk%0d", e), locked, 0);
    end
    check("s2a_hl", half_len, 7);
    check("s2a_ec", edge_count, 6);
    check_errs("s2a", 1, 0, 0);

    // 2b: long half-period
    do_reset();
    for (int e = 1; e <= 6; e++) tw(12);
    check("s2b_hl", half_len, 12);
    check("s2b_lk", locked, 0);
    check_errs("s2b", 0, 1, 0);

    // 2c: tolerance edges 9 and 11 are accepted
    do_reset();
    tw(9); tw(11); tw(9); tw(11);
    check("s2c_lk4", locked, 0);
    check("s2c_hl4", half_len, 9);
    tw(9);
    check("s2c_lk5", locked, 1);
    check("s2c_hl5", half_len, 11);
    check_errs("s2c", 0, 0, 0);

    // 3: stuck after lock, then relock with sticky stuck error
    do_reset();
    repeat (5) tw(10);
    check("s3_lk", locked, 1);
    repeat (23) tick();
    check("s3_pre_stuck", err_stuck, 0);
    check("s3_pre_lk", locked, 1);
    tick();
    check("s3_stuck", err_stuck, 1);
    check("s3_stuck_hl", half_len, 32);
    check("s3_stuck_lk", locked, 0);
    repeat (4) tw(10);
    check("s3_relk4", locked, 0);
    tw(10);
    check("s3_relk5", locked, 1);
    check("s3_err_kept", err_stuck, 1);
    check("s3_ec", edge_count, 10);

    // 6: enable dropped while locked; errors and count hold; re-enable relocks
    enable = 1'b0;
    tick();
    check("s6_lk_off", locked, 0);
    check("s6_stuck_hold", err_stuck, 1);
    check("s6_ec_hold", edge_count, 10);
    tw(10);
    check("s6_ec_disabled", edge_count, 10);
    enable = 1'b1;
    tick();
    tw(10);
    check("s6_ec1", edge_count, 11);
    check("s6_hl1", half_len, 10);
    repeat (3) tw(10);
    check("s6_lk4", locked, 0);
    tw(10);
    check("s6_lk5", locked, 1);
    check("s6_ec5", edge_count, 15);
    check("s6_stuck_still", err_stuck, 1);

    // 4: clear_err coincident with a short detection loses to the set
    do_reset();
    repeat (5) tw(10);
    tw(7);
    check("s4_lk_before", locked, 1);
    check("s4_short_before", err_short, 0);
    mon_in = ~mon_in;
    repeat (2) tick();
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    check("s4_set_wins", err_short, 1);
    check("s4_hl", half_len, 7);
    check("s4_lk_drop", locked, 0);
    repeat (7) tick();
    repeat (4) tw(10);
    check("s4_relk", locked, 1);
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    check_errs("s4_clr", 0, 0, 0);
    check("s4_lk_kept", locked, 1);
    check("s4_ec", edge_count, 11);

    // 5: async reset mid-lock, then mon_in=1 after reset supplies the first edge
    do_reset();
    repeat (5) tw(10);
    check("s5_lk", locked, 1);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("s5_async_lk", locked, 0);
    check("s5_async_hl", half_len, 0);
    check("s5_async_ec", edge_count, 0);
    check_errs("s5_async", 0, 0, 0);
    repeat (2) tick();
    mon_in = 1'b1;
    rst = 1'b0;
    repeat (10) tick();
    check("s5_ec1", edge_count, 1);
    check("s5_hl1", half_len, 0);
    repeat (3) tw(10);
    check("s5_lk4", locked, 0);
    tw(10);
    check("s5_lk5", locked, 1);
    check("s5_ec5", edge_count, 5);
    check("s5_hl5", half_len, 10);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/clk_monitor.md
# clk_monitor

Clock-integrity monitor: the receiving end of a generated clock. It samples a monitored clock `mon_in`, produced by a clock generator, with the system clock `clk`. It measures every half-period, declares lock after a run of in-tolerance half-periods, and raises sticky errors for short, long or stuck half-periods. It sits beside any clock generator in self-checking benches and in designs that must qualify a derived clock before use.

## Interface
Parameters:
- `HALF_PERIOD`, default 10: expected half-period of `mon_in`, in `clk` cycles.
- `TOL`, default 1: allowed deviation ± from `HALF_PERIOD`, in `clk` cycles.
- `LOCK_CNT`, default 4: consecutive good half-periods required for lock.
- `STUCK_LIMIT`, default 32: cycles without an edge before a stuck error; must exceed `HALF_PERIOD+TOL`.
- `CNT_W`, default 8: width of the run counter and `half_len`; 2^CNT_W-1 ≥ `STUCK_LIMIT`.

Ports:
- `clk`, input, 1: system clock; all state on rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `mon_in`, input, 1: monitored clock, asynchronous to `clk`.
- `enable`, input, 1: monitor enable.
- `clear_err`, input, 1: one-cycle pulse that clears sticky errors.
- `locked`, output, 1: monitored clock qualified.
- `err_short`, output, 1: sticky; a half-period was below `HALF_PERIOD-TOL`.
- `err_long`, output, 1: sticky; a half-period was above `HALF_PERIOD+TOL`.
- `err_stuck`, output, 1: sticky; no edge within `STUCK_LIMIT` cycles.
- `half_len`, output, CNT_W: last measured half-period length.
- `edge_count`, output, 16: detected edges while enabled; wraps modulo 2^16.

## Operation
- **Synchronizer:** `mon_in` passes through flops q1→q2, with history flop q3. `edge = q2 ^ q3`, covering both polarities.
- **Run counter:**
  - Clears to 0 on an edge cycle.
  - Otherwise increments, saturating at 2^CNT_W-1.
  - Measured length on an edge is L = run_cnt+1. A `mon_in` toggling every N `clk` cycles gives L = N.
- **States:** IDLE, ACQUIRE, MEASURE, LOCKED.
  - IDLE: entered on reset or whenever `enable`=0, from any state. `locked`=0. Run counter and good-count held at 0. Errors, `half_len` and `edge_count` hold.
  - IDLE→ACQUIRE when `enable`=1.
  - ACQUIRE: the first edge is counted in `edge_count` but not measured. It starts the run counter and moves to MEASURE.
  - MEASURE: on each edge, compute L and load `half_len`.
    - Good L (`HALF_PERIOD-TOL` ≤ L ≤ `HALF_PERIOD+TOL`): good-count increments. When it reaches `LOCK_CNT`, go to LOCKED.
    - L below the range: set `err_short` and zero good-count.
    - L above the range: set `err_long` and zero good-count.
  - LOCKED: `locked`=1. Edges are measured as in MEASURE. A bad L sets the error, zeroes good-count, drops `locked` and returns to MEASURE.
  - Stuck, in MEASURE or LOCKED: when run_cnt+1 reaches `STUCK_LIMIT` with no edge, set `err_stuck`, load `half_len`=`STUCK_LIMIT`, drop `locked`, zero good-count and go to ACQUIRE.
- **Error clearing:** `clear_err` clears all three errors. If an error is set in the same cycle as `clear_err`, the set wins. `clear_err` does not affect `locked` or state.
- **Width rule:** `TOL` > `HALF_PERIOD` makes the lower bound 0. Arithmetic is done at CNT_W+1 bits with no underflow.

## Timing
- Reset values: `locked`=0, all errors=0, `half_len`=0, `edge_count`=0, q1/q2/q3=0, state IDLE. All are applied immediately on `rst` assertion, including mid-lock.
- Latency: when a new `mon_in` level is captured into q1 at `clk` edge k, the outputs reflecting that edge update at edge k+2.
- After reset, `mon_in`=1 yields one edge. In ACQUIRE it counts as the unmeasured first edge.
- `locked` rises on the same edge as the `LOCK_CNT`-th good `half_len` update. That is edge `LOCK_CNT`+1 after acquire.
- Stuck error asserts on the edge where run_cnt becomes `STUCK_LIMIT-1`, i.e. `STUCK_LIMIT` cycles after the last edge pulse.
- `enable` falling: `locked`=0 on the next `clk` edge.

## Test plan
All scenarios use defaults `HALF_PERIOD`=10, `TOL`=1, `LOCK_CNT`=4, `STUCK_LIMIT`=32.
1. `mon_in` toggles every 10 clk and `enable`=1 → `half_len`=10. `locked`=1 at the 5th detected edge, no errors. `edge_count` increments once per toggle.
2. `mon_in` toggles every 7 clk → `err_short`=1, `half_len`=7, `locked` never 1. Every 12 clk → `err_long`=1, `half_len`=12. Toggles at 9 and 11 clk → accepted, lock achieved.
3. Lock, then hold `mon_in` constant → 32 cycles after the last edge pulse: `err_stuck`=1, `half_len`=32, `locked`=0. Resume toggling every 10 → relock after 5 edges, with `err_stuck` still 1.
4. `clear_err` pulsed in the same cycle as a short-period detection → `err_short` remains 1. Pulse again with no error → all errors 0, `locked` unaffected.
5. `rst` asserted mid-lock, between clk edges → all outputs 0 immediately. After release with `mon_in` toggling every 10, `locked`=1 on the 5th edge.
6. `enable` dropped while locked → `locked`=0 next cycle; errors and `edge_count` hold. Re-enable → the first edge is unmeasured, then relock.
